riscmakers_dcache_mem_responder: RTL
====================================

// Module: riscmakers_dcache_mem_responder
// PURPOSE
//  Memory-side responder for the data-cache bypass port: accepts dcache_req_t load/store requests
//  (req/ack handshake) and returns dcache_rtrn_t responses after a fixed latency.
//  Backed by an internal line-wide RAM. Used as the data-memory model behind the L1 dcache in
//  testbenches and in small FPGA builds without an L2 adapter. One transaction in flight.
// PARAMETERS
//  DEPTH_LINES  1024  number of cache-line-wide RAM entries (power of two)
//  LATENCY      2     idle cycles between request capture and response (0 allowed)
// PORTS
//  clk_i            in   1                     clock
//  rst_ni           in   1                     async active-low reset
//  mem_data_req_i   in   1                     request valid from dcache
//  mem_data_ack_o   out  1                     request accepted (same cycle as capture)
//  mem_data_i       in   $bits(dcache_req_t)   rtype,size,paddr,data,tid,nc,amo_op,way
//  mem_rtrn_vld_o   out  1                     one-cycle response valid pulse
//  mem_rtrn_o       out  $bits(dcache_rtrn_t)  rtype,data(DCACHE_LINE_WIDTH),inv,tid
//  busy_o           out  1                     transaction in flight
//  err_o            out  1                     sticky: unsupported rtype/size seen
// BEHAVIOUR
//  - Reset: state IDLE, ack=0, rtrn_vld=0, mem_rtrn_o='0, busy=0, err=0, latency counter=0.
//    RAM contents are NOT reset.
//  - Reset mid-transaction: the in-flight transaction is dropped and no response is issued;
//    a store already written stays written.
//  - FSM IDLE -> WAIT -> RESP -> IDLE.
//  - IDLE: ack_o = req_i (combinational). On req&ack, the request is registered, cnt<=LATENCY,
//    next state WAIT (or RESP when LATENCY=0).
//  - WAIT: ack=0; cnt decrements each cycle; at cnt==1 go to RESP.
//  - RESP: rtrn_vld=1 for exactly one cycle, then IDLE.
//  - Latency: ack in cycle T gives rtrn_vld in cycle T+1+LATENCY. Back-to-back requests: the next
//    ack is possible in the cycle after RESP, never in RESP itself. req_i held while busy is not
//    acked and is not lost.
//  - Line index = paddr[OFF +: log2(DEPTH_LINES)], with OFF = log2(DCACHE_LINE_WIDTH/8).
//    Higher address bits are ignored, so the address space wraps modulo DEPTH_LINES lines.
//  - Store (DCACHE_STORE_REQ): write is performed at the capture edge.
//    - Byte enables from size (0=1B, 1=2B, 2=4B, 3=8B if XLEN=64) at byte offset paddr[OFF-1:0].
//    - Write data is the low bytes of data, replicated/shifted into the lane.
//    - Response: rtype=DCACHE_STORE_ACK, data='0.
//  - Load (DCACHE_LOAD_REQ): the full line at the index is read in the RESP cycle and returned with
//    rtype=DCACHE_LOAD_ACK. The requester extracts the word itself.
//  - Ordering: a load acked after a store's ack observes that store's data.
//  - tid is echoed into mem_rtrn_o.tid; inv='0 always; nc and way are ignored.
//  - Any other rtype (AMO, IFILL), or size that is unaligned/overflows the line:
//    - no RAM write;
//    - response still issued (rtype=DCACHE_LOAD_ACK, data='0);
//    - err_o set until reset.
//  - Requester kills/abandons: the responder always completes; the stale response pulse is still
//    emitted.
//  - mem_rtrn_o holds its last value outside RESP; only rtrn_vld qualifies it.
// TESTING
//  1 Reset held, req_i=1 -> ack=0, rtrn_vld=0, err=0; release -> ack=1 same cycle as req.
//  2 LATENCY=2, store size=2 paddr=0x8000_0004 data=0xDEADBEEF, tid=2 ->
//    STORE_ACK at T+3 with tid=2; load 0x8000_0000 returns line bytes[7:4]=EF BE AD DE.
//  3 Store size=0 paddr=..._0005 data=0x55 over 0xDEADBEEF -> reload word=0xDEAD55EF.
//  4 req_i held continuously with 3 loads -> acks spaced 2+LATENCY cycles apart, one rtrn_vld per
//    ack, tids in order.
//  5 AMO rtype request -> no RAM change, LOAD_ACK with data=0, err_o=1 sticky.
//  6 Assert rst_ni=0 during WAIT -> no rtrn_vld ever issued; post-reset load sees the stored data.

Source files
------------

// File: rtl/riscmakers_dcache_mem_responder.sv
// Data-cache bypass memory responder: line-wide RAM behind a req/ack port,
// one transaction in flight, response pulse a fixed number of cycles after capture.

package riscmakers_dcache_mem_responder_pkg;

  localparam int XLEN               = 64;
  localparam int PLEN               = 32;
  localparam int DCACHE_LINE_WIDTH  = 128;
  localparam int DCACHE_TID_WIDTH   = 4;
  localparam int DCACHE_INDEX_WIDTH = 12;
  localparam int DCACHE_SET_ASSOC   = 4;

  typedef enum logic [2:0] {
    DCACHE_LOAD_REQ   = 3'd0,
    DCACHE_STORE_REQ  = 3'd1,
    DCACHE_ATOMIC_REQ = 3'd2,
    DCACHE_INT_REQ    = 3'd3,
    DCACHE_IFILL_REQ  = 3'd4
  } dcache_out_t;

  typedef enum logic [1:0] {
    DCACHE_LOAD_ACK   = 2'd0,
    DCACHE_STORE_ACK  = 2'd1,
    DCACHE_ATOMIC_ACK = 2'd2,
    DCACHE_INV_REQ    = 2'd3
  } dcache_in_t;

  typedef struct packed {
    logic                                vld;
    logic                                all;
    logic [DCACHE_INDEX_WIDTH-1:0]       idx;
    logic [$clog2(DCACHE_SET_ASSOC)-1:0] way;
  } dcache_inval_t;

  typedef struct packed {
    dcache_out_t                         rtype;
    logic [2:0]                          size;
    logic [PLEN-1:0]                     paddr;
    logic [XLEN-1:0]                     data;
    logic [DCACHE_TID_WIDTH-1:0]         tid;
    logic                                nc;
    logic [3:0]                          amo_op;
    logic [$clog2(DCACHE_SET_ASSOC)-1:0] way;
  } dcache_req_t;

  typedef struct packed {
    dcache_in_t                          rtype;
    logic [DCACHE_LINE_WIDTH-1:0]        data;
    dcache_inval_t                       inv;
    logic [DCACHE_TID_WIDTH-1:0]         tid;
  } dcache_rtrn_t;

endpackage

module riscmakers_dcache_mem_responder
  import riscmakers_dcache_mem_responder_pkg::*;
#(
  parameter int DEPTH_LINES = 1024,
  parameter int LATENCY     = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         mem_data_req_i,
  output logic         mem_data_ack_o,
  input  dcache_req_t  mem_data_i,
  output logic         mem_rtrn_vld_o,
  output dcache_rtrn_t mem_rtrn_o,
  output logic         busy_o,
  output logic         err_o
);

  localparam int LINE_BYTES = DCACHE_LINE_WIDTH / 8;
  localparam int OFF        = $clog2(LINE_BYTES);
  localparam int IW         = $clog2(DEPTH_LINES);
  localparam int CW         = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        err_q, err_d;
  logic                        store_q, store_d;
  logic                        bad_q, bad_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [DCACHE_TID_WIDTH-1:0] tid_q, tid_d;
  dcache_rtrn_t                rtrn_q, rtrn_d;

  logic [DCACHE_LINE_WIDTH-1:0] ram [DEPTH_LINES];

  logic [IW-1:0]                in_idx;
  logic [OFF-1:0]               in_off;
  logic                         size_ok;
  logic                         in_bad;
  logic                         in_store;
  logic [LINE_BYTES-1:0]        be_mask;
  logic [LINE_BYTES-1:0]        wr_be;
  logic [DCACHE_LINE_WIDTH-1:0] wr_line;
  logic                         capture;
  logic                         wr_en;
  dcache_rtrn_t                 rtrn_now;
  logic                         unused_req_bits;

  assign in_idx   = mem_data_i.paddr[OFF +: IW];
  assign in_off   = mem_data_i.paddr[OFF-1:0];
  assign in_store = (mem_data_i.rtype == DCACHE_STORE_REQ);

  // nc, way, amo_op and address bits above the RAM index have no effect here
  assign unused_req_bits = ^{mem_data_i.nc, mem_data_i.amo_op, mem_data_i.way,
                             mem_data_i.paddr[PLEN-1:OFF+IW]};

  // Size decode: natural alignment check and the unshifted byte-lane mask
  always_comb begin
    size_ok = 1'b0;
    be_mask = '0;
    case (mem_data_i.size)
      3'd0: begin
        size_ok     = 1'b1;
        be_mask[0]  = 1'b1;
      end
      3'd1: begin
        size_ok      = ~in_off[0];
        be_mask[1:0] = '1;
      end
      3'd2: begin
        size_ok      = (in_off[1:0] == 2'd0);
        be_mask[3:0] = '1;
      end
      3'd3: begin
        size_ok      = (XLEN == 64) && (in_off[2:0] == 3'd0);
        be_mask[7:0] = '1;
      end
      default: begin
        size_ok = 1'b0;
        be_mask = '0;
      end
    endcase
  end

  // An aligned access of at most 8 bytes can never cross a 16-byte line
  assign in_bad  = !((mem_data_i.rtype == DCACHE_LOAD_REQ) || in_store) || !size_ok;
  assign wr_be   = be_mask << in_off;
  assign wr_line = {{(DCACHE_LINE_WIDTH-XLEN){1'b0}}, mem_data_i.data} << {in_off, 3'b000};

  // Acks only in IDLE, and never while reset is applied
  assign mem_data_ack_o = mem_data_req_i & rst_ni & (state_q == S_IDLE);
  assign capture        = mem_data_req_i & mem_data_ack_o;
  assign wr_en          = capture & in_store & ~in_bad;

  // Store lands in the RAM on the capture edge so a following load always sees it
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < LINE_BYTES; b++) begin
        if (wr_be[b]) begin
          ram[in_idx][b*8 +: 8] <= wr_line[b*8 +: 8];
        end
      end
    end
  end

  // Response built from the captured request; load data read in the RESP cycle
  always_comb begin
    rtrn_now       = '0;
    rtrn_now.tid   = tid_q;
    rtrn_now.inv   = '0;
    rtrn_now.rtype = (store_q && !bad_q) ? DCACHE_STORE_ACK : DCACHE_LOAD_ACK;
    if (!store_q && !bad_q) begin
      rtrn_now.data = ram[idx_q];
    end
  end

  // Next-state logic: capture in IDLE, count down in WAIT, one-cycle pulse in RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    store_d = store_q;
    bad_d   = bad_q;
    idx_d   = idx_q;
    tid_d   = tid_q;
    rtrn_d  = rtrn_q;
    case (state_q)
      S_IDLE: begin
        if (capture) begin
          store_d = in_store;
          bad_d   = in_bad;
          idx_d   = in_idx;
          tid_d   = mem_data_i.tid;
          err_d   = err_q | in_bad;
          cnt_d   = CW'(LATENCY);
          state_d = (LATENCY == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CW'(1)) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rtrn_d  = rtrn_now;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and request registers; reset drops any in-flight transaction
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      store_q <= 1'b0;
      bad_q   <= 1'b0;
      idx_q   <= '0;
      tid_q   <= '0;
      rtrn_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      store_q <= store_d;
      bad_q   <= bad_d;
      idx_q   <= idx_d;
      tid_q   <= tid_d;
      rtrn_q  <= rtrn_d;
    end
  end

  assign mem_rtrn_vld_o = (state_q == S_RESP);
  assign mem_rtrn_o     = (state_q == S_RESP) ? rtrn_now : rtrn_q;
  assign busy_o         = (state_q != S_IDLE);
  assign err_o          = err_q;

endmodule
